// File: rtl/triangle_assembler_pkg.sv
//------------------------------------------------------------------------------
// Module   : triangle_assembler_pkg
// Brief    : Shared vertex-pipeline widths, vertex field layout, FSM encoding.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package triangle_assembler_pkg;

   localparam int DW_VERTEX = 64;
   localparam int AW        = 16;
   localparam int CW        = 16;

   // Vertex word field layout shared with vertex_transform
   localparam int C_X_MSB   = 63;
   localparam int C_X_LSB   = 48;
   localparam int C_Y_MSB   = 47;
   localparam int C_Y_LSB   = 32;
   localparam int C_Z_MSB   = 31;
   localparam int C_Z_LSB   = 16;
   localparam int C_COL_MSB = 15;
   localparam int C_COL_LSB = 8;
   localparam int C_PAD_MSB = 7;
   localparam int C_PAD_LSB = 4;
   localparam int C_UV_MSB  = 3;
   localparam int C_UV_LSB  = 0;

   localparam logic [2:0] C_ST_IDLE   = 3'd0;
   localparam logic [2:0] C_ST_REQ    = 3'd1;
   localparam logic [2:0] C_ST_RESP   = 3'd2;
   localparam logic [2:0] C_ST_LAUNCH = 3'd3;
   localparam logic [2:0] C_ST_WAIT   = 3'd4;
   localparam logic [2:0] C_ST_NEXT   = 3'd5;
   localparam logic [2:0] C_ST_FIN    = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE   = C_ST_IDLE,
      ST_REQ    = C_ST_REQ,
      ST_RESP   = C_ST_RESP,
      ST_LAUNCH = C_ST_LAUNCH,
      ST_WAIT   = C_ST_WAIT,
      ST_NEXT   = C_ST_NEXT,
      ST_FIN    = C_ST_FIN
   } state_t;

   localparam logic [AW-1:0] C_ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] C_CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

endpackage

`default_nettype wire

// File: rtl/triangle_assembler_if.sv
//------------------------------------------------------------------------------
// Module   : triangle_assembler_if
// Brief    : Control, vertex-read and vertex_transform handshake bundle.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface triangle_assembler_if import triangle_assembler_pkg::*;;

   logic                 kick;
   logic                 abort;
   logic [AW-1:0]        base_addr;
   logic [CW-1:0]        tri_count;
   logic                 mem_rd_en;
   logic [AW-1:0]        mem_rd_addr;
   logic [DW_VERTEX-1:0] mem_rd_data;
   logic                 mem_rd_valid;
   logic [DW_VERTEX-1:0] xf_v0;
   logic [DW_VERTEX-1:0] xf_v1;
   logic [DW_VERTEX-1:0] xf_v2;
   logic                 xf_start;
   logic                 xf_done;
   logic                 busy;
   logic [CW-1:0]        tri_idx;
   logic                 done;

   modport master (
      input  kick, abort, base_addr, tri_count, mem_rd_data, mem_rd_valid, xf_done,
      output mem_rd_en, mem_rd_addr, xf_v0, xf_v1, xf_v2, xf_start, busy, tri_idx, done
   );

   modport slave (
      output kick, abort, base_addr, tri_count, mem_rd_data, mem_rd_valid, xf_done,
      input  mem_rd_en, mem_rd_addr, xf_v0, xf_v1, xf_v2, xf_start, busy, tri_idx, done
   );

endinterface

`default_nettype wire

// File: rtl/triangle_assembler.sv
//------------------------------------------------------------------------------
// Module   : triangle_assembler
// Brief    : Fetches triangles (3 vertex words each) and feeds vertex_transform.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module triangle_assembler import triangle_assembler_pkg::*; (
   input  logic                 CLK,
   input  logic                 rst_n,
   triangle_assembler_if.master bus
);

   state_t               r_state;
   logic [AW-1:0]        r_addr_ptr;
   logic [CW-1:0]        r_cnt;
   logic [CW-1:0]        r_tri_idx;
   logic [1:0]           r_vsel;
   logic [DW_VERTEX-1:0] r_v0;
   logic [DW_VERTEX-1:0] r_v1;
   logic [DW_VERTEX-1:0] r_v2;
   logic                 r_mem_rd_en;
   logic                 r_xf_start;
   logic                 r_done;
   logic                 r_busy;

   // Pulse outputs are set on the transition into their state so they are
   // high for exactly the cycle spent in REQ / LAUNCH / FIN.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_addr_ptr  <= '0;
         r_cnt       <= '0;
         r_tri_idx   <= '0;
         r_vsel      <= '0;
         r_v0        <= '0;
         r_v1        <= '0;
         r_v2        <= '0;
         r_mem_rd_en <= 1'b0;
         r_xf_start  <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_mem_rd_en <= 1'b0;
         r_xf_start  <= 1'b0;
         r_done      <= 1'b0;
         if (bus.abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (bus.kick) begin
                     r_addr_ptr <= bus.base_addr;
                     r_cnt      <= bus.tri_count;
                     r_tri_idx  <= '0;
                     r_vsel     <= '0;
                     r_busy     <= 1'b1;
                     if (bus.tri_count == '0) begin
                        r_state <= ST_FIN;
                        r_done  <= 1'b1;
                     end else begin
                        r_state     <= ST_REQ;
                        r_mem_rd_en <= 1'b1;
                     end
                  end
               end
               ST_REQ: r_state <= ST_RESP;
               ST_RESP: begin
                  if (bus.mem_rd_valid) begin
                     case (r_vsel)
                        2'd0:    r_v0 <= bus.mem_rd_data;
                        2'd1:    r_v1 <= bus.mem_rd_data;
                        default: r_v2 <= bus.mem_rd_data;
                     endcase
                     r_addr_ptr <= r_addr_ptr + C_ADDR_ONE;
                     if (r_vsel == 2'd2) begin
                        r_state    <= ST_LAUNCH;
                        r_xf_start <= 1'b1;
                     end else begin
                        r_vsel      <= r_vsel + 2'd1;
                        r_state     <= ST_REQ;
                        r_mem_rd_en <= 1'b1;
                     end
                  end
               end
               ST_LAUNCH: r_state <= ST_WAIT;
               ST_WAIT: begin
                  if (bus.xf_done) r_state <= ST_NEXT;
               end
               ST_NEXT: begin
                  if (r_tri_idx == r_cnt - C_CNT_ONE) begin
                     r_state <= ST_FIN;
                     r_done  <= 1'b1;
                  end else begin
                     r_tri_idx   <= r_tri_idx + C_CNT_ONE;
                     r_vsel      <= '0;
                     r_state     <= ST_REQ;
                     r_mem_rd_en <= 1'b1;
                  end
               end
               ST_FIN: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.mem_rd_en   = r_mem_rd_en;
   assign bus.mem_rd_addr = r_addr_ptr;
   assign bus.xf_v0       = r_v0;
   assign bus.xf_v1       = r_v1;
   assign bus.xf_v2       = r_v2;
   assign bus.xf_start    = r_xf_start;
   assign bus.busy        = r_busy;
   assign bus.tri_idx     = r_tri_idx;
   assign bus.done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_triangle_assembler.sv
//------------------------------------------------------------------------------
// Module   : tb_triangle_assembler
// Brief    : Table-driven scoreboard bench for triangle_assembler.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_triangle_assembler;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   triangle_assembler_if bus();

   triangle_assembler dut (
      .CLK   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [15:0] base;
      logic [15:0] count;
      int          mlat;
      int          xlat;
      int          exp_reads;
      int          exp_starts;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic [15:0] idx;
      logic [63:0] v0;
      logic [63:0] v1;
      logic [63:0] v2;
   } tri_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          n_reads, n_starts, n_done;
   int          mem_lat = 1, xf_lat = 2;
   int          mem_cd  = 0, xf_cd = 0;
   int          kick_cyc, done_cyc, last_start_cyc, last_xfdone;
   bit          gap_valid = 1'b0;
   logic [15:0] mem_addr_q;
   logic        mem_vld  = 1'b0;
   logic [63:0] mem_dat  = '0;
   logic        xf_model = 1'b0;
   logic        spur     = 1'b0;
   logic [15:0] exp_addr[$];
   tri_t        tri_q[$];

   assign bus.mem_rd_valid = mem_vld;
   assign bus.mem_rd_data  = mem_dat;
   assign bus.xf_done      = xf_model | spur;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] mem_word(input logic [15:0] a);
      logic [3:0] n;
      n = a[3:0] + 4'd1;
      return {16{n}};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_evt(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: event occurred, expected none", name);
   endtask

   // Memory model, vertex_transform model and scoreboard, sampled mid-cycle
   always @(negedge clk) begin
      tri_t t;
      mem_vld = 1'b0;
      if (mem_cd > 0) begin
         mem_cd--;
         if (mem_cd == 0) begin
            mem_vld = 1'b1;
            mem_dat = mem_word(mem_addr_q);
         end
      end
      if (bus.mem_rd_en) begin
         n_reads++;
         if (exp_addr.size() == 0) fail_evt("rd_unexpected");
         else check("rd_addr", bus.mem_rd_addr, exp_addr.pop_front());
         mem_addr_q = bus.mem_rd_addr;
         mem_cd     = mem_lat;
      end
      xf_model = 1'b0;
      if (xf_cd > 0) begin
         xf_cd--;
         if (xf_cd == 0) begin
            xf_model    = 1'b1;
            last_xfdone = cyc;
            gap_valid   = 1'b1;
         end
      end
      if (bus.xf_start) begin
         n_starts++;
         if (tri_q.size() == 0) fail_evt("xf_start_unexpected");
         else begin
            t = tri_q.pop_front();
            check("tri_idx", bus.tri_idx, t.idx);
            check("xf_v0", bus.xf_v0, t.v0);
            check("xf_v1", bus.xf_v1, t.v1);
            check("xf_v2", bus.xf_v2, t.v2);
         end
         if (gap_valid) check("xf_gap_ge3", (cyc - last_xfdone) >= 3, 1);
         xf_cd          = xf_lat;
         last_start_cyc = cyc;
      end
      if (bus.done) begin
         n_done++;
         done_cyc = cyc;
      end
   end

   task automatic push_draw(input logic [15:0] base, input logic [15:0] count);
      tri_t        t;
      logic [15:0] a;
      for (int i = 0; i < int'(count); i++) begin
         a     = base + 16'(3 * i);
         t.idx = 16'(i);
         t.v0  = mem_word(a);
         t.v1  = mem_word(a + 16'd1);
         t.v2  = mem_word(a + 16'd2);
         tri_q.push_back(t);
         for (int k = 0; k < 3; k++) exp_addr.push_back(a + 16'(k));
      end
   endtask

   // Called at #1 after a rising edge; returns at #1 after the edge that samples kick
   task automatic do_kick(input vec_t v);
      mem_lat   = v.mlat;
      xf_lat    = v.xlat;
      n_reads   = 0;
      n_starts  = 0;
      n_done    = 0;
      gap_valid = 1'b0;
      push_draw(v.base, v.count);
      bus.base_addr = v.base;
      bus.tri_count = v.count;
      bus.kick      = 1'b1;
      kick_cyc      = cyc;
      @(posedge clk); #1;
      bus.kick = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(posedge clk);
         if (n_done > 0) break;
      end
      #1;
      if (i == budget) fail_evt({tag, "_done_timeout"});
   endtask

   task automatic wait_reads(input int n, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(posedge clk);
         if (n_reads >= n) break;
      end
      if (i == budget) fail_evt("reads_timeout");
   endtask

   // Latency counts rising edges from the kick-sampling edge's predecessor
   // to the edge that samples done high.
   task automatic finish_draw(input vec_t v, input string tag);
      check({tag, "_lat"}, done_cyc - kick_cyc + 1, v.exp_lat);
      repeat (4) @(posedge clk);
      #1;
      check({tag, "_reads"},  n_reads,  v.exp_reads);
      check({tag, "_starts"}, n_starts, v.exp_starts);
      check({tag, "_dones"},  n_done,   1);
      check({tag, "_busy"},   bus.busy, 1'b0);
      check({tag, "_addr_q"}, exp_addr.size(), 0);
      check({tag, "_tri_q"},  tri_q.size(), 0);
   endtask

   vec_t vecs[5];
   vec_t v;

   initial begin
      // base, count, mem lat, xf lat, reads, starts, kick-to-done edges
      vecs[0] = '{16'h0010, 16'd1, 1, 2,  3, 1, 12};
      vecs[1] = '{16'hFFFE, 16'd3, 3, 4,  9, 3, 56};
      vecs[2] = '{16'h0000, 16'd0, 1, 2,  0, 0,  2};
      vecs[3] = '{16'h1234, 16'd2, 2, 1,  6, 2, 26};
      vecs[4] = '{16'h7FF0, 16'd4, 1, 3, 12, 4, 46};

      bus.kick      = 1'b1;
      bus.abort     = 1'b0;
      bus.base_addr = 16'h1234;
      bus.tri_count = 16'd5;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",     bus.busy, 1'b0);
      check("rst_rd_en",    bus.mem_rd_en, 1'b0);
      check("rst_rd_addr",  bus.mem_rd_addr, 16'h0);
      check("rst_xf_start", bus.xf_start, 1'b0);
      check("rst_done",     bus.done, 1'b0);
      check("rst_tri_idx",  bus.tri_idx, 16'h0);
      check("rst_xf_v",     bus.xf_v0 | bus.xf_v1 | bus.xf_v2, 64'h0);
      bus.kick = 1'b0;
      rst_n    = 1'b1;
      n_reads  = 0;
      repeat (5) @(posedge clk);
      #1;
      check("post_rst_no_read", n_reads, 0);
      check("post_rst_busy",    bus.busy, 1'b0);

      for (int i = 0; i < 5; i++) begin
         do_kick(vecs[i]);
         wait_done($sformatf("vec%0d", i), 600);
         finish_draw(vecs[i], $sformatf("vec%0d", i));
      end

      // Abort in RESP of triangle 1, vertex 1; its read response lands in IDLE
      v = '{16'h0100, 16'd3, 3, 2, 0, 0, 0};
      do_kick(v);
      wait_reads(5, 300);
      #1;
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      check("abort_busy",    bus.busy, 1'b0);
      check("abort_tri_idx", bus.tri_idx, 16'd1);
      repeat (6) @(posedge clk);
      #1;
      check("abort_no_done", n_done, 0);
      check("abort_reads",   n_reads, 5);
      check("abort_starts",  n_starts, 1);
      check("abort_busy2",   bus.busy, 1'b0);
      check("abort_v0",      bus.xf_v0, mem_word(16'h0103));
      check("abort_v1",      bus.xf_v1, mem_word(16'h0101));
      check("abort_v2",      bus.xf_v2, mem_word(16'h0102));
      exp_addr.delete();
      tri_q.delete();
      v = '{16'h0040, 16'd1, 1, 2, 3, 1, 12};
      do_kick(v);
      wait_done("post_abort", 200);
      finish_draw(v, "post_abort");

      // Slow vertex_transform, spurious xf_done in RESP, kick while in WAIT
      v = '{16'h0200, 16'd2, 3, 20, 6, 2, 70};
      do_kick(v);
      wait_reads(1, 50);
      #1;
      spur = 1'b1;
      @(posedge clk); #1;
      spur = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         if (n_starts > 0) break;
      end
      repeat (5) @(posedge clk);
      #1;
      check("bp_wait_busy", bus.busy, 1'b1);
      bus.base_addr = 16'h5555;
      bus.tri_count = 16'd7;
      bus.kick      = 1'b1;
      @(posedge clk); #1;
      bus.kick = 1'b0;
      wait_done("bp", 300);
      check("bp_wait_len", done_cyc - last_start_cyc, 22);
      finish_draw(v, "bp");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/triangle_assembler.md
Name: triangle_assembler

Overview:
- Upstream feeder for vertex_transform.
- On a kick, reads tri_count triangles from a flat vertex buffer. Each triangle is 3 consecutive 64-bit vertex words.
- For each triangle: latches the three vertices, pulses xf_start, then waits for xf_done before fetching the next triangle.
- Signals completion to the command/control logic with a one-cycle done pulse.

Parameters:
- DW_VERTEX, 64, vertex word width; must match vertex_transform.
- AW, 16, vertex-buffer word address width.
- CW, 16, triangle count/index width.

Ports:
- CLK  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- kick  in  1  start a draw; sampled only in IDLE.
- abort  in  1  synchronous cancel; overrides everything except reset.
- base_addr  in  AW  word address of vertex 0 of triangle 0.
- tri_count  in  CW  number of triangles; latched on an accepted kick.
- mem_rd_en  out  1  one-cycle read request.
- mem_rd_addr  out  AW  read address, valid with mem_rd_en.
- mem_rd_data  in  DW_VERTEX  read data.
- mem_rd_valid  in  1  read data valid; latency 1..N cycles, at most one read outstanding.
- xf_v0, xf_v1, xf_v2  out  DW_VERTEX  triangle vertices to vertex_transform.
- xf_start  out  1  one-cycle pulse to vertex_transform.
- xf_done  in  1  vertex_transform completion pulse.
- busy  out  1  high in every state except IDLE.
- tri_idx  out  CW  index of the triangle currently in flight.
- done  out  1  one-cycle pulse when a draw completes.

Behaviour:
- Reset (async assert, sync deassert): state IDLE; all outputs 0, including xf_v0..2, tri_idx, mem_rd_addr.
- States: IDLE, REQ, RESP, LAUNCH, WAIT, NEXT, FIN.
- IDLE, on kick:
  - latch base_addr into addr_ptr and tri_count into cnt; tri_idx<=0; vsel<=0.
  - cnt==0 -> FIN; else -> REQ.
- REQ: mem_rd_en=1 for exactly one cycle, mem_rd_addr=addr_ptr -> RESP.
- RESP, on mem_rd_valid:
  - store mem_rd_data into vertex slot vsel (0->xf_v0, 1->xf_v1, 2->xf_v2).
  - addr_ptr<=addr_ptr+1 (wraps mod 2^AW).
  - vsel<2 -> vsel+1, REQ; vsel==2 -> LAUNCH.
- LAUNCH: xf_start=1 for one cycle -> WAIT.
  - xf_v0..2 are stable from the LAUNCH cycle until the next RESP write. vertex_transform samples them on start.
- WAIT, on xf_done -> NEXT.
  - Latency from xf_start to xf_done is not assumed.
- NEXT:
  - tri_idx==cnt-1 -> FIN.
  - else tri_idx<=tri_idx+1, vsel<=0 -> REQ.
- FIN: done=1 for one cycle -> IDLE.
- Start spacing: the next xf_start is at least 3 cycles after xf_done (NEXT + 3×REQ/RESP). This meets vertex_transform's requirement that it has returned to idle.
- Minimum cycles per triangle with 1-cycle memory latency: 6 (fetch) + 1 (LAUNCH) + WAIT + 1 (NEXT).
- kick while busy: ignored, with no effect on the latched cnt/base.
- mem_rd_valid outside RESP: ignored.
- xf_done outside WAIT: ignored.
- abort in any non-IDLE state -> IDLE next cycle.
  - No done pulse; tri_idx holds its last value; xf_v* hold.
  - A read response still in flight after abort is ignored; it arrives in IDLE.
- kick and abort in the same IDLE cycle: abort wins, kick dropped.
- tri_count = 2^CW-1 is legal. The address pointer wraps silently.

Decomposition:
- Shared pipeline package: DW_VERTEX, the vertex field offsets (x 63:48, y 47:32, z 31:16, col 15:8, pad 7:4, uv 3:0), the state encoding localparams.
- No sub-module. A single FSM with an address counter, a vertex-slot counter and a triangle counter.

Test Plan:
- Reset: hold rst_n=0 with kick=1 -> all outputs 0, busy=0. Release -> no mem_rd_en until a kick is sampled.
- Single triangle:
  - setup: base_addr=0x0010, tri_count=1, memory returns 0x1111..., 0x2222..., 0x3333... at latency 1; model vertex_transform returns xf_done 2 cycles after start.
  - expected: reads at 0x10, 0x11, 0x12; xf_v0/1/2 equal those words at xf_start; done 1 cycle after NEXT; exactly one xf_start.
- Three triangles, latency 3:
  - setup: base_addr=0xFFFE, tri_count=3.
  - expected: 9 reads; addresses 0xFFFE, 0xFFFF, 0x0000..0x0006; tri_idx 0,1,2 at each xf_start; gap from each xf_done to the next xf_start >= 3 cycles; one done pulse.
- tri_count=0 -> done pulses 2 cycles after kick; no mem_rd_en, no xf_start.
- Abort:
  - setup: abort asserted in RESP of triangle 1 (vsel=1), with the read response arriving after the abort.
  - expected: IDLE next cycle, no done, busy=0, stale response ignored; a new kick with tri_count=1 completes normally.
- Back-pressure and spurious pulses:
  - setup: xf_done delayed 20 cycles; kick pulsed during WAIT; spurious xf_done pulsed during RESP.
  - expected: FSM stays in WAIT for the full 20 cycles; kick has no effect; spurious xf_done ignored; done counts match tri_count.
